instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch-side partner of the PC register. Reads PCout, fetches the instruction from
//  instruction memory over a req/ack interface and presents {instr, pc} to decode
//  with a valid/ready handshake. Drives PCin every cycle: hold, advance by PC_STEP,
//  or take a branch/jump redirect. The PC register has no write enable, so holding
//  the PC is done by driving PCin = PCout.
// PARAMETERS
//  XLEN       32         address/instruction width
//  RESET_PC   32'h0      PCin driven during reset; equals the PC register reset value
//  PC_STEP    4          sequential increment, in bytes
//  NOP_INSTR  32'h0      id_instr value after reset and after a flush
// PORTS
//  Clk          in   1     clock; all state updates on posedge
//  Rst_n        in   1     synchronous, active-low reset
//  PCout        in   XLEN  current PC, from the PC register
//  PCin         out  XLEN  next PC, to the PC register (combinational)
//  imem_req     out  1     instruction memory read request (level)
//  imem_addr    out  XLEN  read address; equals PCout
//  imem_ack     in   1     one-cycle data-valid strobe; ignored unless imem_req=1
//  imem_rdata   in   XLEN  instruction word; valid when imem_ack=1
//  redirect     in   1     taken branch/jump from EX, single-cycle pulse
//  redirect_pc  in   XLEN  target address; bits [1:0] forced to 00
//  id_valid     out  1     the IF/ID slot holds a valid instruction
//  id_ready     in   1     decode accepts the slot this cycle
//  id_instr     out  XLEN  fetched instruction
//  id_pc        out  XLEN  address of id_instr
//  id_pc4       out  XLEN  id_pc + PC_STEP (link value)
// BEHAVIOUR
//  Reset (Rst_n=0 at posedge):
//   - state <= S_IDLE; id_valid=0; id_instr=NOP_INSTR; id_pc=0; hold buffer empty.
//   - imem_req=0. While Rst_n=0, PCin = RESET_PC.
//  FSM states: S_IDLE, S_REQ, S_FULL, S_REDIR.
//   S_IDLE : imem_req=0; PCin=PCout. Next state is S_REQ (one bubble after reset).
//   S_REQ  : imem_req=1; imem_addr=PCout.
//     - No ack: PCin=PCout; stay in S_REQ.
//     - Ack with slot free (!id_valid | id_ready): load id_* from {imem_rdata, PCout};
//       id_valid<=1; PCin=PCout+PC_STEP; stay in S_REQ.
//     - Ack with slot busy: store {imem_rdata, PCout} in the hold buffer;
//       PCin=PCout+PC_STEP; go to S_FULL.
//   S_FULL : imem_req=0; PCin=PCout. When id_ready=1: id_* <= hold buffer,
//            id_valid stays 1, then go to S_REQ.
//   S_REDIR: imem_req=0; PCin=PCout; then go to S_REQ. This state lets the new PC settle.
//  Decode handshake: transfer occurs when id_valid & id_ready. After a transfer with
//   no new load, id_valid <= 0. id_* stay stable while id_valid=1 and id_ready=0.
//  Redirect (highest priority, any state except reset):
//   - PCin = {redirect_pc[XLEN-1:2], 2'b00}.
//   - id_valid<=0; id_instr<=NOP_INSTR; hold buffer emptied; next state is S_REDIR.
//   - An imem_ack in the same cycle is discarded.
//   - Redirect-to-first-new-request latency is 2 cycles.
//  Memory rules:
//   - imem_addr is stable while imem_req=1 and no ack has arrived.
//   - The unit drops imem_req only on redirect or on entry to S_FULL/S_IDLE.
//   - The memory must accept an abandoned (unacked) request.
//  Arithmetic: PCout+PC_STEP is mod 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
//   id_pc4 wraps the same way.
//  Simultaneous events:
//   - redirect+ack: redirect wins.
//   - ack+id_ready with slot full: the load counts as slot-free.
//   - Rst_n=0 overrides everything, including mid-wait and S_FULL.
//  Throughput: 1 instr/cycle with a 0-wait memory and id_ready held at 1.
// STRUCTURE
//  - Package fetch_pkg:
//    - fetch_state_t enum {S_IDLE, S_REQ, S_FULL, S_REDIR};
//    - localparams NOP_INSTR, PC_STEP, RESET_PC.
//  - Sub-module fetch_skid_buf: output register plus one hold entry for {instr, pc},
//    with load/pop/flush ports.
//  - The FSM and PCin mux live in the top module.
// TESTING
//  1. Hold Rst_n=0 for 3 cycles, then release -> PCin=0, id_valid=0, imem_req=0 for 1 cycle,
//     then a request at addr 0.
//  2. Memory with 0 waits returns rdata=addr^32'hA5A5_0000; id_ready=1 ->
//     id_pc=0,4,8,... on consecutive cycles.
//  3. 2-cycle ack delay -> imem_addr stable, PCin=PCout during the wait;
//     one id_valid per 3 cycles.
//  4. id_ready=0 for 5 cycles -> state S_FULL, imem_req=0; id_pc=0 then 4 after release;
//     no instruction lost or duplicated.
//  5. Redirect to 32'h0000_0103 while an ack is present and the slot is full ->
//     ack dropped, id_valid=0, next request at 32'h100 two cycles later.
//  6. Redirect to 32'hFFFF_FFFC -> fetches 0xFFFFFFFC then 0x0; id_pc4 for the first
//     instruction = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FULL  = 2'd2,
        S_REDIR = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ack bus, EX redirect and the IF/ID valid/ready slot.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc4;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        output id_valid, id_instr, id_pc, id_pc4,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        input  id_valid, id_instr, id_pc, id_pc4,
        output id_ready
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// IF/ID output register with one hold entry that catches a fetch returning while decode stalls.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] FLUSH_INSTR = XLEN'(NOP_INSTR)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic            ready_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q,    out_pc_d;
    logic            hold_valid_q, hold_valid_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q,    hold_pc_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            out_instr_d  = FLUSH_INSTR;
            hold_valid_d = 1'b0;
        end else begin
            if (load_i) begin
                out_valid_d = 1'b1;
                out_instr_d = instr_i;
                out_pc_d    = pc_i;
            end else if (pop_i && hold_valid_q) begin
                out_valid_d  = 1'b1;
                out_instr_d  = hold_instr_q;
                out_pc_d     = hold_pc_q;
                hold_valid_d = 1'b0;
            end else if (ready_i) begin
                // Slot consumed by decode (or already empty) with nothing to replace it.
                out_valid_d = 1'b0;
            end

            if (push_i) begin
                hold_valid_d = 1'b1;
                hold_instr_d = instr_i;
                hold_pc_d    = pc_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= FLUSH_INSTR;
            out_pc_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= FLUSH_INSTR;
            hold_pc_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign valid_o = out_valid_q;
    assign instr_o = out_instr_q;
    assign pc_o    = out_pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the next PC every cycle, fetches over req/ack and feeds decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(fetch_pkg::RESET_PC),
    parameter logic [XLEN-1:0] PC_STEP   = XLEN'(fetch_pkg::PC_STEP),
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [XLEN-1:0]   PCout,
    output logic [XLEN-1:0]   PCin,
    instr_fetch_unit_if.master bus
);

    fetch_state_t state_q, state_d;
    logic         slot_free;
    logic         load;
    logic         push;
    logic         pop;
    logic         flush;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

    assign slot_free     = !bus.id_valid || bus.id_ready;
    assign bus.imem_addr = PCout;
    assign bus.id_pc4    = seq_pc(bus.id_pc);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The PC register has no enable: every non-advancing cycle must feed PCout back.
    always_comb begin
        state_d      = state_q;
        PCin         = PCout;
        bus.imem_req = 1'b0;
        load         = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;

        if (!Rst_n) begin
            PCin = RESET_PC;
        end else begin
            bus.imem_req = (state_q == S_REQ);
            if (bus.redirect) begin
                PCin    = align_pc(bus.redirect_pc);
                flush   = 1'b1;
                state_d = S_REDIR;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_d = S_REQ;
                    end
                    S_REQ: begin
                        if (bus.imem_ack) begin
                            PCin = seq_pc(PCout);
                            if (slot_free) begin
                                load = 1'b1;
                            end else begin
                                push    = 1'b1;
                                state_d = S_FULL;
                            end
                        end
                    end
                    S_FULL: begin
                        if (bus.id_ready) begin
                            pop     = 1'b1;
                            state_d = S_REQ;
                        end
                    end
                    default: begin
                        state_d = S_REQ;
                    end
                endcase
            end
        end
    end

    fetch_skid_buf #(
        .XLEN        (XLEN),
        .FLUSH_INSTR (NOP_INSTR)
    ) u_skid (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .load_i  (load),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .ready_i (bus.id_ready),
        .instr_i (bus.imem_rdata),
        .pc_i    (PCout),
        .valid_o (bus.id_valid),
        .instr_o (bus.id_instr),
        .pc_o    (bus.id_pc)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised and directed bench for instr_fetch_unit against an in-order fetch-stream model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int          XLEN = 32;
    localparam logic [31:0] KEY  = 32'hA5A5_0000;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] PCout;
    logic [31:0] PCin;

    int unsigned lat      = 0;
    int unsigned wait_cnt = 0;
    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          n_xfer   = 0;
    logic [31:0] exp_pc   = 32'h0;

    logic        prev_ok, prev_req, prev_ack, prev_redir, prev_valid, prev_ready;
    logic [31:0] prev_addr, prev_pc, prev_instr;

    instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

    instr_fetch_unit #(.XLEN(XLEN)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .PCout (PCout),
        .PCin  (PCin),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // PC register and a memory that answers after 'lat' waiting cycles.
    always @(posedge Clk) PCout <= PCin;

    always @(posedge Clk) begin
        if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
    end

    assign bus.imem_ack   = bus.imem_req && (wait_cnt >= lat);
    assign bus.imem_rdata = bus.imem_addr ^ KEY;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic monitor();
        logic [31:0] want_pcin;
        if (Rst_n) begin
            if (bus.redirect)                        want_pcin = bus.redirect_pc & 32'hFFFF_FFFC;
            else if (bus.imem_req && bus.imem_ack)   want_pcin = PCout + 32'd4;
            else                                     want_pcin = PCout;
            check("pcin", PCin, want_pcin);
            if (bus.imem_req) check("imem_addr", bus.imem_addr, PCout);
            if (prev_ok && prev_req && !prev_ack && !prev_redir && bus.imem_req)
                check("addr_stable", bus.imem_addr, prev_addr);
            if (prev_ok && prev_valid && !prev_ready && !prev_redir) begin
                check("stall_valid", bus.id_valid, 1'b1);
                check("stall_pc", bus.id_pc, prev_pc);
                check("stall_instr", bus.id_instr, prev_instr);
            end
            if (prev_ok && prev_redir) begin
                check("flush_valid", bus.id_valid, 1'b0);
                check("flush_instr", bus.id_instr, NOP_INSTR);
                check("flush_req", bus.imem_req, 1'b0);
            end
            if (bus.id_valid && bus.id_ready) begin
                check("id_pc", bus.id_pc, exp_pc);
                check("id_instr", bus.id_instr, exp_pc ^ KEY);
                check("id_pc4", bus.id_pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_xfer++;
            end
            if (bus.redirect) exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end
        prev_ok    = Rst_n;
        prev_req   = bus.imem_req;
        prev_ack   = bus.imem_ack;
        prev_redir = bus.redirect;
        prev_valid = bus.id_valid;
        prev_ready = bus.id_ready;
        prev_addr  = bus.imem_addr;
        prev_pc    = bus.id_pc;
        prev_instr = bus.id_instr;
    endtask

    task automatic drive(input logic rdy, input logic rd, input logic [31:0] tgt);
        bus.id_ready    = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = tgt;
        #1;
        monitor();
    endtask

    task automatic adv();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int c;
        bit seen;
        Rst_n = 1'b0;
        prev_ok = 1'b0;
        bus.id_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;

        // Reset held for three cycles
        #1;
        check("rst_pcin", PCin, RESET_PC);
        check("rst_req", bus.imem_req, 1'b0);
        repeat (3) adv();
        check("rst_valid", bus.id_valid, 1'b0);
        check("rst_instr", bus.id_instr, NOP_INSTR);
        check("rst_idpc", bus.id_pc, 32'h0);
        check("rst_pcin2", PCin, RESET_PC);
        Rst_n = 1'b1;

        drive(1'b1, 1'b0, 32'h0);
        check("idle_req", bus.imem_req, 1'b0);
        check("idle_pcin", PCin, 32'h0);
        check("idle_valid", bus.id_valid, 1'b0);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        check("first_req", bus.imem_req, 1'b1);
        check("first_addr", bus.imem_addr, 32'h0);
        adv();

        // Zero-wait memory streams one instruction per cycle
        c = n_xfer;
        repeat (8) begin drive(1'b1, 1'b0, 32'h0); adv(); end
        check("tput_0wait", n_xfer - c, 8);

        // Two waiting cycles per fetch: one instruction every three cycles
        lat = 2;
        repeat (3) begin drive(1'b1, 1'b0, 32'h0); adv(); end
        c = n_xfer;
        repeat (9) begin drive(1'b1, 1'b0, 32'h0); adv(); end
        check("tput_2wait", n_xfer - c, 3);

        // Decode stall fills the hold entry and parks the fetch
        lat = 0;
        drive(1'b1, 1'b1, 32'h0);
        adv();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            if (i >= 3) begin
                check("full_req", bus.imem_req, 1'b0);
                check("full_valid", bus.id_valid, 1'b1);
                check("full_pc", bus.id_pc, 32'h0);
            end
            adv();
        end
        drive(1'b1, 1'b0, 32'h0);
        check("rel_pc0", bus.id_pc, 32'h0);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        check("rel_pc4", bus.id_pc, 32'h4);
        check("rel_valid", bus.id_valid, 1'b1);
        adv();
        repeat (3) begin drive(1'b1, 1'b0, 32'h0); adv(); end

        // Redirect coinciding with an ack while the slot is full
        drive(1'b0, 1'b1, 32'h0000_0103);
        check("r5_ack", bus.imem_ack, 1'b1);
        check("r5_slot", bus.id_valid, 1'b1);
        check("r5_pcin", PCin, 32'h0000_0100);
        adv();
        drive(1'b0, 1'b0, 32'h0);
        check("r5_valid", bus.id_valid, 1'b0);
        check("r5_req", bus.imem_req, 1'b0);
        check("r5_pcout", PCout, 32'h0000_0100);
        adv();
        drive(1'b0, 1'b0, 32'h0);
        check("r5_req2", bus.imem_req, 1'b1);
        check("r5_addr", bus.imem_addr, 32'h0000_0100);
        adv();
        repeat (4) begin drive(1'b1, 1'b0, 32'h0); adv(); end

        // Redirect to the top of the address space wraps to zero
        drive(1'b1, 1'b1, 32'hFFFF_FFFC);
        adv();
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            c = n_xfer;
            drive(1'b1, 1'b0, 32'h0);
            if (n_xfer != c) begin
                seen = 1'b1;
                check("wrap_pc", bus.id_pc, 32'hFFFF_FFFC);
                check("wrap_pc4", bus.id_pc4, 32'h0);
            end
            adv();
        end
        check("wrap_seen", seen, 1'b1);
        drive(1'b1, 1'b0, 32'h0);
        check("wrap_next", bus.id_pc, 32'h0);
        adv();

        // Reset while parked in the full state
        repeat (4) begin drive(1'b0, 1'b0, 32'h0); adv(); end
        Rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        check("mrst_pcin", PCin, RESET_PC);
        check("mrst_req", bus.imem_req, 1'b0);
        adv();
        check("mrst_valid", bus.id_valid, 1'b0);
        check("mrst_instr", bus.id_instr, NOP_INSTR);
        Rst_n = 1'b1;
        exp_pc = RESET_PC;

        // Random traffic: stalls, memory latency and rare redirects
        c = n_xfer;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) lat = $urandom_range(0, 3);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
            adv();
        end
        check("rand_progress", n_xfer - c > 40, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
